// File: rtl/axi4_burst_traffic_checker.sv
// AXI4 master that writes G_NUM_BURSTS INCR bursts of a known pattern, reads them back and counts errors.
// Optional macro AXI4_TRAFFIC_CHECKER_RESP_CHECK_EN: count every non-OKAY bresp/rresp beat as an error.
module axi4_burst_traffic_checker #(
  parameter int G_ADDR_WIDTH = 7,
  parameter int G_DATA_WIDTH = 32,
  parameter int G_ID_WIDTH   = 1,
  parameter int G_BURST_LEN  = 4,
  parameter int G_NUM_BURSTS = 2,
  parameter int G_BASE_ADDR  = 0
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               error_count,
  // write address channel
  output logic [G_ID_WIDTH-1:0]     m_awid,
  output logic [G_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic [1:0]                m_awlock,
  output logic [3:0]                m_awcache,
  output logic [2:0]                m_awprot,
  output logic [3:0]                m_awqos,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  // write data channel
  output logic [G_ID_WIDTH-1:0]     m_wid,
  output logic [G_DATA_WIDTH-1:0]   m_wdata,
  output logic [G_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  // write response channel
  input  logic [G_ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  // read address channel
  output logic [G_ID_WIDTH-1:0]     m_arid,
  output logic [G_ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic [1:0]                m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic [3:0]                m_arqos,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  // read data channel
  input  logic [G_ID_WIDTH-1:0]     m_rid,
  input  logic [G_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int                      C_BYTES      = G_DATA_WIDTH / 8;
  localparam logic [2:0]              C_SIZE       = 3'($clog2(C_BYTES));
  localparam logic [7:0]              C_LEN        = 8'(G_BURST_LEN - 1);
  localparam logic [15:0]             C_LAST_BURST = 16'(G_NUM_BURSTS - 1);
  localparam logic [G_ADDR_WIDTH-1:0] C_BASE       = G_ADDR_WIDTH'(G_BASE_ADDR);
  localparam logic [G_ADDR_WIDTH-1:0] C_STRIDE     = G_ADDR_WIDTH'(G_BURST_LEN * C_BYTES);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t                    r_state;
  logic                      r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
  logic                      r_busy, r_done;
  logic [15:0]               r_error_count;
  logic [15:0]               r_burst;
  logic [7:0]                r_beat;
  logic [31:0]               r_gbeat;
  logic [G_ADDR_WIDTH-1:0]   r_addr;
  logic [G_DATA_WIDTH-1:0]   r_wdata;

  function automatic logic [G_DATA_WIDTH-1:0] f_pattern(input logic [31:0] g);
    logic [31:0] w;
    w = 32'hA5A5_0000 + g;
    return G_DATA_WIDTH'(w);
  endfunction

  function automatic logic [15:0] f_sat_add(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + 17'(n);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic w_bresp_err, w_rresp_err;
`ifdef AXI4_TRAFFIC_CHECKER_RESP_CHECK_EN
  assign w_bresp_err = (m_bresp != 2'b00);
  assign w_rresp_err = (m_rresp != 2'b00);
  wire   w_unused    = &{1'b0, m_bid, m_rid};
`else
  assign w_bresp_err = 1'b0;
  assign w_rresp_err = 1'b0;
  wire   w_unused    = &{1'b0, m_bid, m_rid, m_bresp, m_rresp};
`endif

  // Termination follows our own beat count; m_rlast is only checked against it.
  logic       w_last_beat, w_last_burst, w_data_err, w_rlast_err;
  logic [1:0] w_r_err_inc;
  assign w_last_beat  = (r_beat == C_LEN);
  assign w_last_burst = (r_burst == C_LAST_BURST);
  assign w_data_err   = (m_rdata != f_pattern(r_gbeat));
  assign w_rlast_err  = (m_rlast != w_last_beat);
  assign w_r_err_inc  = 2'(w_data_err) + 2'(w_rlast_err) + 2'(w_rresp_err);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_wlast       <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error_count <= 16'h0;
      r_burst       <= 16'h0;
      r_beat        <= 8'h0;
      r_gbeat       <= 32'h0;
      r_addr        <= C_BASE;
      r_wdata       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_error_count <= 16'h0;
            r_burst       <= 16'h0;
            r_beat        <= 8'h0;
            r_gbeat       <= 32'h0;
            r_addr        <= C_BASE;
            r_awvalid     <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_state       <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (r_awvalid && m_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wdata   <= f_pattern(r_gbeat);
            r_wlast   <= (C_LEN == 8'd0);
            r_beat    <= 8'h0;
            r_state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (r_wvalid && m_wready) begin
            r_gbeat <= r_gbeat + 32'd1;
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_beat   <= 8'h0;
              r_bready <= 1'b1;
              r_state  <= WR_RESP;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_wdata <= f_pattern(r_gbeat + 32'd1);
              r_wlast <= (r_beat + 8'd1 == C_LEN);
            end
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            r_bready      <= 1'b0;
            r_error_count <= f_sat_add(r_error_count, 2'(w_bresp_err));
            if (w_last_burst) begin
              r_burst   <= 16'h0;
              r_gbeat   <= 32'h0;
              r_addr    <= C_BASE;
              r_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end else begin
              r_burst   <= r_burst + 16'd1;
              r_addr    <= r_addr + C_STRIDE;
              r_awvalid <= 1'b1;
              r_state   <= WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (r_arvalid && m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= 8'h0;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            r_error_count <= f_sat_add(r_error_count, w_r_err_inc);
            r_gbeat       <= r_gbeat + 32'd1;
            if (w_last_beat) begin
              r_beat   <= 8'h0;
              r_rready <= 1'b0;
              if (w_last_burst) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_burst   <= r_burst + 16'd1;
                r_addr    <= r_addr + C_STRIDE;
                r_arvalid <= 1'b1;
                r_state   <= RD_ADDR;
              end
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_done && (r_error_count == 16'h0);
  assign error_count = r_error_count;

  assign m_awid    = '0;
  assign m_awaddr  = r_addr;
  assign m_awlen   = C_LEN;
  assign m_awsize  = C_SIZE;
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'h0;
  assign m_awprot  = 3'h0;
  assign m_awqos   = 4'h0;
  assign m_awvalid = r_awvalid;

  assign m_wid     = '0;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = '1;
  assign m_wlast   = r_wlast;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;

  assign m_arid    = '0;
  assign m_araddr  = r_addr;
  assign m_arlen   = C_LEN;
  assign m_arsize  = C_SIZE;
  assign m_arburst = 2'b01;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'h0;
  assign m_arprot  = 3'h0;
  assign m_arqos   = 4'h0;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

endmodule

// File: tb/tb_axi4_burst_traffic_checker.sv
// Self-checking bench: reactive AXI4 slave with fault knobs, scoreboard queues for AW/AR/W and pass results.
module tb_axi4_burst_traffic_checker;

  localparam int BL = 4;
  localparam int NB = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] error_count;

  logic [0:0]  m_awid, m_wid, m_arid;
  logic [0:0]  m_bid = 1'b0, m_rid = 1'b0;
  logic [6:0]  m_awaddr, m_araddr;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]  m_awburst, m_arburst, m_awlock, m_arlock;
  logic [3:0]  m_awcache, m_arcache, m_awqos, m_arqos;
  logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0;
  logic        m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0] m_rdata = 32'h0;

  always #5 clock = ~clock;

  axi4_burst_traffic_checker dut (
    .clock(clock), .resetn(resetn), .start(start),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] err;
    logic        pass_exp;
  } res_t;

  logic [31:0] q_aw[$];
  logic [31:0] q_ar[$];
  logic [32:0] q_w[$];
  res_t        q_res[$];

  // fault knobs
  bit wready_toggle = 1'b0, bresp_err_once = 1'b0, rflip = 1'b0, rlast_early = 1'b0;
  int aw_delay_cnt = 0, aw_exp_hold = 1;

  // slave state
  logic [31:0] mem [0:31];
  bit          aw_busy, b_pend, r_busy, tog, aw_addr_changed, bresp_used;
  int          w_base, w_beat, r_base, r_beat, rd_burst_idx, aw_hold, w_total;
  logic [6:0]  aw_last_addr;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;

  // Outputs are driven on the falling edge; the handshake taking effect at the next rising edge
  // is evaluated right after, while both sides' values are settled.
  always @(negedge clock) begin
    if (!resetn) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0;
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = 32'h0; m_bresp = 2'b00;
      aw_busy = 1'b0; b_pend = 1'b0; r_busy = 1'b0; aw_hold = 0; aw_addr_changed = 1'b0;
      w_beat = 0; r_beat = 0;
    end else begin
      if (m_awvalid && !aw_busy && !b_pend) begin
        aw_hold++;
        if (aw_hold > 1 && m_awaddr != aw_last_addr) aw_addr_changed = 1'b1;
        aw_last_addr = m_awaddr;
        if (aw_delay_cnt > 0) begin
          m_awready = 1'b0;
          aw_delay_cnt--;
        end else begin
          m_awready = 1'b1;
        end
      end else begin
        m_awready = 1'b0;
      end
      m_wready  = aw_busy && (wready_toggle ? tog : 1'b1);
      tog       = !tog;
      m_bvalid  = b_pend;
      m_bresp   = (bresp_err_once && !bresp_used) ? 2'b10 : 2'b00;
      m_arready = m_arvalid && !r_busy;
      m_rvalid  = r_busy;
      if (r_busy) begin
        m_rdata = mem[r_base + r_beat] ^ 32'((rflip && rd_burst_idx == 1 && r_beat == 2) ? 1 : 0);
        m_rlast = (rlast_early && rd_burst_idx == 0) ? (r_beat == 1) : (r_beat == BL - 1);
      end else begin
        m_rdata = 32'h0;
        m_rlast = 1'b0;
      end

      if (m_awvalid && m_awready) begin
        if (q_aw.size() == 0) check("aw_extra", 32'd1, 32'd0);
        else check("awaddr", 32'(m_awaddr), q_aw.pop_front());
        check("awlen", 32'(m_awlen), 32'(BL - 1));
        check("awsize", 32'(m_awsize), 32'd2);
        check("awburst", 32'(m_awburst), 32'd1);
        check("aw_hold_cycles", 32'(aw_hold), 32'(aw_exp_hold));
        check("aw_stable", 32'(aw_addr_changed), 32'd0);
        aw_exp_hold = 1; aw_hold = 0; aw_addr_changed = 1'b0;
        aw_busy = 1'b1; w_base = int'(m_awaddr >> 2); w_beat = 0;
      end
      if (m_wvalid && m_wready) begin
        if (q_w.size() == 0) check("w_extra", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = q_w.pop_front();
          check("wdata", m_wdata, e[31:0]);
          check("wlast", 32'(m_wlast), 32'(e[32]));
        end
        check("wstrb", 32'(m_wstrb), 32'hF);
        mem[w_base + w_beat] = m_wdata;
        w_beat++; w_total++;
        if (w_beat == BL) begin
          aw_busy = 1'b0;
          b_pend  = 1'b1;
        end
      end
      if (m_bvalid && m_bready) begin
        b_pend = 1'b0;
        if (m_bresp != 2'b00) bresp_used = 1'b1;
      end
      if (m_arvalid && m_arready) begin
        if (q_ar.size() == 0) check("ar_extra", 32'd1, 32'd0);
        else check("araddr", 32'(m_araddr), q_ar.pop_front());
        check("arlen", 32'(m_arlen), 32'(BL - 1));
        r_busy = 1'b1; r_base = int'(m_araddr >> 2); r_beat = 0;
      end
      if (m_rvalid && m_rready) begin
        r_beat++;
        if (r_beat == BL) begin
          r_busy = 1'b0;
          rd_burst_idx++;
        end
      end
    end
  end

  task automatic push_expected(input logic [15:0] exp_err, input int delay);
    res_t r;
    for (int b = 0; b < NB; b++) begin
      q_aw.push_back(32'(b * BL * 4));
      q_ar.push_back(32'(b * BL * 4));
      for (int k = 0; k < BL; k++)
        q_w.push_back({k == BL - 1, 32'hA5A5_0000 + 32'(b * BL + k)});
    end
    r.err = exp_err;
    r.pass_exp = (exp_err == 16'h0);
    q_res.push_back(r);
    aw_exp_hold = delay + 1; aw_delay_cnt = delay;
    rd_burst_idx = 0; bresp_used = 1'b0; w_total = 0;
  endtask

  task automatic run_pass(input logic [15:0] exp_err, input int delay);
    bit seen;
    push_expected(exp_err, delay);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    start = 1'b1;                       // must be ignored while busy
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      res_t r;
      r = q_res.pop_front();
      check("error_count", 32'(error_count), 32'(r.err));
      check("pass", 32'(pass), 32'(r.pass_exp));
      check("busy_at_done", 32'(busy), 32'd0);
      check("w_beats", 32'(w_total), 32'(NB * BL));
      check("w_queue_left", 32'(q_w.size()), 32'd0);
      check("ar_queue_left", 32'(q_ar.size()), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] resp_err;
    bit          got2;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_awvalid", 32'(m_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_wvalid), 32'd0);
    check("rst_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_bready", 32'(m_bready), 32'd0);
    check("rst_rready", 32'(m_rready), 32'd0);
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("idle_awvalid", 32'(m_awvalid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    run_pass(16'd0, 0);
    for (int i = 0; i < NB * BL; i++) check("mem_word", mem[i], 32'hA5A5_0000 + 32'(i));

    rflip = 1'b1;
    run_pass(16'd1, 0);
    rflip = 1'b0;

    wready_toggle = 1'b1;
    run_pass(16'd0, 5);
    wready_toggle = 1'b0;

    rlast_early = 1'b1;
    run_pass(16'd2, 0);
    rlast_early = 1'b0;

`ifdef AXI4_TRAFFIC_CHECKER_RESP_CHECK_EN
    resp_err = 16'd1;
`else
    resp_err = 16'd0;
`endif
    bresp_err_once = 1'b1;
    run_pass(resp_err, 0);
    bresp_err_once = 1'b0;

    // reset in the middle of write beat 2
    push_expected(16'd0, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    got2 = 1'b0;
    for (int c = 0; c < 200 && !got2; c++) begin
      @(posedge clock); #1;
      if (w_total >= 2) got2 = 1'b1;
    end
    check("beat2_reached", 32'(got2), 32'd1);
    check("beat2_wvalid", 32'(m_wvalid), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_wvalid", 32'(m_wvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_awvalid", 32'(m_awvalid), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    q_aw.delete(); q_ar.delete(); q_w.delete(); q_res.delete();
    @(posedge clock); #1;
    run_pass(16'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
